// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: major opcodes and the immediate format tag.
package rv32_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // funct3 values of the OP-IMM shift instructions (slli / srli / srai)
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRL = 3'b101;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational opcode classifier and immediate assembly for RV32I.
module imm_decode
  import rv32_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] immediate,
  output imm_type_e   imm_type
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       sign;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign sign   = instr[31];

  // Classify the opcode and assemble the sign-extended immediate for that format.
  always_comb begin
    immediate = '0;
    imm_type  = IMM_NONE;
    case (opcode)
      OP_LOAD, OP_JALR, OP_SYSTEM: begin
        imm_type  = IMM_I;
        immediate = {{20{sign}}, instr[31:20]};
      end
      OP_IMM: begin
        imm_type = IMM_I;
        // Shifts carry only a 5-bit shamt; funct7 bits are not part of the value.
        if (funct3 == F3_SLL || funct3 == F3_SRL)
          immediate = {27'd0, instr[24:20]};
        else
          immediate = {{20{sign}}, instr[31:20]};
      end
      OP_STORE: begin
        imm_type  = IMM_S;
        immediate = {{20{sign}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        imm_type  = IMM_B;
        immediate = {{19{sign}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        imm_type  = IMM_U;
        immediate = {instr[31:12], 12'h000};
      end
      OP_JAL: begin
        imm_type  = IMM_J;
        immediate = {{11{sign}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: begin
        immediate = '0;
        imm_type  = IMM_NONE;
      end
    endcase
  end

endmodule

// File: rtl/imm_extender.sv
// RV32I immediate generator: same-cycle immediate plus a stallable pipeline copy.
module imm_extender
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        stall,
  output logic [31:0] immediate,
  output logic [2:0]  imm_type,
  output logic [31:0] immediate_q,
  output logic [2:0]  imm_type_q
);

  imm_type_e   type_comb;
  imm_type_e   type_reg;
  logic [31:0] imm_reg;

  imm_decode u_decode (
    .instr     (instr),
    .immediate (immediate),
    .imm_type  (type_comb)
  );

  assign imm_type    = type_comb;
  assign immediate_q = imm_reg;
  assign imm_type_q  = type_reg;

  // Decode/execute pipeline copy: reset clears, stall holds, otherwise capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imm_reg  <= '0;
      type_reg <= IMM_NONE;
    end else if (!stall) begin
      imm_reg  <= immediate;
      type_reg <= type_comb;
    end
  end

endmodule

// File: tb/tb_imm_extender.sv
// Scoreboard bench for imm_extender: randomized and directed instruction words.
module tb_imm_extender;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        stall;
  logic [31:0] immediate;
  logic [2:0]  imm_type;
  logic [31:0] immediate_q;
  logic [2:0]  imm_type_q;

  imm_extender dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .stall       (stall),
    .immediate   (immediate),
    .imm_type    (imm_type),
    .immediate_q (immediate_q),
    .imm_type_q  (imm_type_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] imm;
    logic [2:0]  typ;
    logic [31:0] imm_q;
    logic [2:0]  typ_q;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;
  int step_id  = 0;

  logic [31:0] model_imm_q;
  logic [2:0]  model_typ_q;

  // Reference: immediate value computed arithmetically from field weights.
  function automatic void ref_model(input logic [31:0] w, output logic [31:0] v,
                                    output logic [2:0] t);
    int x;
    x = 0;
    t = 3'd0;
    case (w[6:0])
      7'h03, 7'h67, 7'h73: begin
        t = 3'd1;
        x = int'(w[30:20]) - (w[31] ? 2048 : 0);
      end
      7'h13: begin
        t = 3'd1;
        if (w[14:12] == 3'd1 || w[14:12] == 3'd5) x = int'(w[24:20]);
        else x = int'(w[30:20]) - (w[31] ? 2048 : 0);
      end
      7'h23: begin
        t = 3'd2;
        x = int'(w[11:7]) + int'(w[30:25]) * 32 - (w[31] ? 2048 : 0);
      end
      7'h63: begin
        t = 3'd3;
        x = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048
            - (w[31] ? 4096 : 0);
      end
      7'h37, 7'h17: begin
        t = 3'd4;
        x = int'(w & 32'hffff_f000);
      end
      7'h6f: begin
        t = 3'd5;
        x = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096
            - (w[31] ? (1 << 20) : 0);
      end
      default: begin
        t = 3'd0;
        x = 0;
      end
    endcase
    v = 32'(x);
  endfunction

  task automatic check(input int id, input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL step%0d %s actual=%h required=%h", id, name, act, req);
    end
  endtask

  // One cycle: advance the model register at the edge, then apply new inputs.
  task automatic step(input logic [31:0] w, input logic s, input logic r);
    exp_t e;
    logic [31:0] v;
    logic [2:0]  t;
    @(posedge clk);
    if (!rst && !stall) ref_model(instr, model_imm_q, model_typ_q);
    #1;
    instr = w;
    stall = s;
    rst   = r;
    if (r) begin
      model_imm_q = '0;
      model_typ_q = 3'd0;
    end
    ref_model(w, v, t);
    e.id    = step_id;
    e.imm   = v;
    e.typ   = t;
    e.imm_q = model_imm_q;
    e.typ_q = model_typ_q;
    sb.push_back(e);
    step_id++;
  endtask

  // Monitor: outputs are stable mid-cycle, compare there against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.id, "immediate",   immediate,           e.imm);
        check(e.id, "imm_type",    {29'd0, imm_type},   {29'd0, e.typ});
        check(e.id, "immediate_q", immediate_q,         e.imm_q);
        check(e.id, "imm_type_q",  {29'd0, imm_type_q}, {29'd0, e.typ_q});
      end
    end
  end

  logic [6:0] ops [10] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63,
                           7'h37, 7'h17, 7'h6f, 7'h7f};

  initial begin
    logic [31:0] w;
    int wait_cycles;
    rst   = 1'b1;
    stall = 1'b0;
    instr = '0;
    model_imm_q = '0;
    model_typ_q = 3'd0;

    // reset state, then directed vectors
    step(32'h0000_0013, 1'b0, 1'b1);
    step(32'hffdf_f0ef, 1'b0, 1'b0);
    step(32'hffdf_f0ef, 1'b0, 1'b0);
    step(32'h0283_0283, 1'b0, 1'b0);
    step(32'h4051_5513, 1'b0, 1'b0);
    step(32'hfe92_46e3, 1'b0, 1'b0);
    step(32'h0012_9023, 1'b0, 1'b0);
    step(32'h0000_1117, 1'b0, 1'b0);
    step(32'hffff_ff7f, 1'b0, 1'b0);

    // stall hold, then asynchronous reset mid-stall and release
    step(32'hffdf_f0ef, 1'b0, 1'b0);
    step(32'h0012_9023, 1'b1, 1'b0);
    step(32'hfe92_46e3, 1'b1, 1'b0);
    step(32'h0000_1117, 1'b1, 1'b1);
    step(32'h0000_1117, 1'b0, 1'b0);
    step(32'hfe92_46e3, 1'b0, 1'b0);

    // randomized words over all formats, with random stall and rare reset
    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) w[6:0] = 7'($urandom);
      step(w, ($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0));
    end

    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d pending required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_extender.md
# imm_extender

Immediate generator for the RV32I decode stage. Takes a raw 32-bit instruction word, classifies its immediate format (I/S/B/U/J) from the opcode, and produces the sign-extended 32-bit immediate combinationally for same-cycle use by the ALU and branch unit. A clocked copy of the immediate and its format tag is also kept for the decode/execute pipeline register.

## Interface
Parameters: none.

Ports:
- clk  in  1  single clock; all registered outputs update on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- instr  in  32  raw instruction word.
- stall  in  1  when 1, the registered outputs hold their value.
- immediate  out  32  combinational sign-extended immediate.
- imm_type  out  3  combinational format tag:
  - 0 NONE
  - 1 I
  - 2 S
  - 3 B
  - 4 U
  - 5 J
- immediate_q  out  32  registered `immediate`.
- imm_type_q  out  3  registered `imm_type`.

## Operation
Format is selected by opcode `instr[6:0]`:
- I: 0000011 (load), 0010011 (OP-IMM), 1100111 (JALR), 1110011 (SYSTEM). Immediate = sext(instr[31:20]).
  - OP-IMM shift exception: when funct3 `instr[14:12]` is 001 or 101, immediate = zero-extended `instr[24:20]` (shamt only).
- S: 0100011. Immediate = sext({instr[31:25], instr[11:7]}).
- B: 1100011. Immediate = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}). Bit 0 is always 0.
- U: 0110111 (LUI), 0010111 (AUIPC). Immediate = {instr[31:12], 12'h000}; no further extension.
- J: 1101111. Immediate = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- Any other opcode: immediate = 0, imm_type = NONE.
- Sign extension always replicates instr[31].
- No illegal-instruction flag is raised; unrecognised opcodes only produce the NONE output.

## Timing
- `immediate` and `imm_type` are purely combinational from `instr`: zero-cycle latency, no dependence on clk, rst or stall.
- `immediate_q` and `imm_type_q` have one-cycle latency:
  - On each rising clk edge with stall=0 they load the current combinational values.
  - With stall=1 they hold.
- rst asserted (asynchronously, at any time, including mid-stall) forces `immediate_q` = 32'h0 and `imm_type_q` = NONE immediately. Both stay there while rst is high.
- The first load after rst deasserts occurs on the first rising edge with stall=0.
- stall and rst asserted together: rst wins.

## Structure
- Shared package `rv32_pkg`:
  - opcode constants (OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL);
  - the 3-bit imm_type enum.
- One natural sub-module: `imm_decode`, the purely combinational opcode classifier plus format assembly.
- Top level instantiates `imm_decode` and adds the reset/stall output register.

## Test plan
1. J-type: instr=32'hffdff0ef → immediate=32'hfffffffc, imm_type=J; after one clk edge (stall=0), immediate_q=32'hfffffffc.
2. I-type load: instr=32'h02830283 → immediate=32'h00000028, imm_type=I. Shift case: instr=32'h40515513 (srai) → immediate=32'h00000005.
3. B-type: instr=32'hfe9246e3 → immediate=32'hffffffec, imm_type=B.
4. S-type and U-type:
   - instr=32'h00129023 → immediate=32'h00000000, imm_type=S;
   - instr=32'h00001117 → immediate=32'h00001000, imm_type=U.
5. Unknown opcode: instr=32'hffffff7f → immediate=0, imm_type=NONE.
6. Register control:
   - load 32'hffdff0ef, then assert stall and change instr → immediate_q stays 32'hfffffffc;
   - assert rst between clock edges → immediate_q=0 and imm_type_q=NONE without waiting for a clk edge.
